sha_mem_arbiter: RTL

SHA_MEM_ARBITER -- requirements
Module: sha_mem_arbiter

---
 rtl/sha_pkg.sv | 17 +
 rtl/sha_rr_pick.sv | 33 +++
 rtl/sha_mem_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// Shared types and default sizes for the SHA memory arbiter.
//   arb_state_t  : arbiter FSM state (IDLE = no owner, OWNED = locked burst)
//   DEF_NUM_REQ  : default number of requesters
//   DEF_ADDR_W   : default memory address width
//   DEF_DATA_W   : default memory data width
package sha_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_t;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_DATA_W  = 32;

endpackage

// File: rtl/sha_rr_pick.sv
// Combinational round-robin picker.
//   req : per-requester request vector
//   ptr : index that has highest priority this cycle
//   gnt : one-hot winner (lowest index at or after ptr, wrapping), zero if no req
module sha_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt
);

   always_comb begin
      logic            found;
      int              idx;
      logic [ID_W-1:0] sel;
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         sel = ID_W'(idx);
         if (!found && req[sel]) begin
            gnt[sel] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sha_mem_arbiter.sv
// Memory arbiter: N requesters share one synchronous single-port memory.
// Round-robin arbitration with per-requester burst lock; reads tracked by a
// 2-deep (valid, id) pipeline so rvalid follows the memory's 1-cycle latency.
// Define SHA_MEM_ARB_FIXED_PRIO_EN for fixed (lowest index wins) arbitration.
//   clk, reset_n             : clock, async active-low reset
//   req/lock/req_we          : per-requester request, burst hold, write enable
//   req_addr/req_wdata       : per-requester address/data, flattened, requester 0 in LSBs
//   gnt                      : one-hot-or-zero combinational grant
//   rvalid/rdata             : read return (rdata shared, rvalid selects owner)
//   mem_clk/mem_we/mem_addr/mem_write_data/mem_read_data : memory port
//
// state | meaning
// IDLE  | no owner; arbitrate every cycle
// OWNED | owner_q holds the bus for a locked burst; others wait
import sha_pkg::*;

module sha_mem_arbiter #(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        lock,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic                      mem_clk,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_write_data,
   input  logic [DATA_W-1:0]         mem_read_data
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t          state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [ID_W-1:0]     owner_q, owner_d;
   logic [ID_W-1:0]     pick_ptr;
   logic [ID_W-1:0]     win_id;
   logic [NUM_REQ-1:0]  pick_gnt;
   logic                accept;
   logic                pipe0_v, pipe1_v;
   logic [ID_W-1:0]     pipe0_id, pipe1_id;

`ifdef SHA_MEM_ARB_FIXED_PRIO_EN
   // Highest priority is always index 0, so the picker degenerates to fixed priority.
   assign pick_ptr = '0;
`else
   assign pick_ptr = ptr_q;
`endif

   sha_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req (req),
      .ptr (pick_ptr),
      .gnt (pick_gnt)
   );

   always_comb begin
      gnt     = '0;
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      win_id  = '0;

      // Grant is forced low while reset is asserted, even with requests pending.
      if (reset_n) begin
         case (state_q)
            IDLE:    gnt = pick_gnt;
            OWNED:   if (req[owner_q]) gnt[owner_q] = 1'b1;
            default: gnt = '0;
         endcase
      end

      // gnt is always a subset of req, so any grant bit is an accepted transfer.
      accept = |gnt;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) win_id = ID_W'(i);
      end

      if (accept) begin
         ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (accept && lock[win_id]) begin
               state_d = OWNED;
               owner_d = win_id;
            end
         end
         OWNED: begin
            // Final unlocked transfer (if requested) was accepted above via gnt.
            if (!req[owner_q] || !lock[owner_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         ptr_q          <= '0;
         owner_q        <= '0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
         pipe0_v        <= 1'b0;
         pipe0_id       <= '0;
         pipe1_v        <= 1'b0;
         pipe1_id       <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         mem_we   <= accept & req_we[win_id];
         if (accept) begin
            mem_addr       <= req_addr[win_id*ADDR_W +: ADDR_W];
            mem_write_data <= req_wdata[win_id*DATA_W +: DATA_W];
         end
         // Stage 0: address just issued; stage 1: memory data now on mem_read_data.
         pipe0_v  <= accept & ~req_we[win_id];
         pipe0_id <= win_id;
         pipe1_v  <= pipe0_v;
         pipe1_id <= pipe0_id;
      end
   end

   always_comb begin
      rvalid = '0;
      if (pipe1_v) rvalid[pipe1_id] = 1'b1;
   end

   assign rdata   = mem_read_data;
   assign mem_clk = clk;

endmodule
